// File: rtl/moore_machine_ws_pkg.sv
// Shared encodings for the multicycle MIPS control FSM with memory wait states:
// state codes, opcodes and control-bus field encodings.
package moore_ws_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WR   = 4'd4,
        WB_MEM   = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        WB_ALU   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_FUNCT = 4'b1111;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] branch;
        logic       reg_src;
        logic       reg_write;
        logic       sn;
    } ctrl_t;

    // States that hold a memory access open and are therefore watched by the timer.
    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/moore_machine_ws_if.sv
// Control bus between the controller and DataPathTop, including the memory handshake.
interface moore_machine_ws_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         Opcode;
    logic               mem_ready;
    logic               mem_req;
    logic               MemWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [3:0]         ALUOp;
    logic               IRWrite;
    logic               PCWrite;
    logic [1:0]         PCSrc;
    logic [1:0]         Branch;
    logic               RegSrc;
    logic               RegWrite;
    logic               SN;
    logic [STATE_W-1:0] Stateout;
    logic               err;
    logic               err_cause;

    modport master (
        input  Opcode, mem_ready,
        output mem_req, MemWrite, ALUSrcA, ALUSrcB, ALUOp, IRWrite, PCWrite,
               PCSrc, Branch, RegSrc, RegWrite, SN, Stateout, err, err_cause
    );

    modport slave (
        output Opcode, mem_ready,
        input  mem_req, MemWrite, ALUSrcA, ALUSrcB, ALUOp, IRWrite, PCWrite,
               PCSrc, Branch, RegSrc, RegWrite, SN, Stateout, err, err_cause
    );
endinterface

// File: rtl/moore_machine_ws_wait_timer.sv
// Counts stalled cycles in a memory state and flags a bus timeout on the last
// allowed stalled cycle. MAX_WAIT=0 disables the timeout.
module wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic mem_ready,
    input  logic clr,
    output logic timeout
);
    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (active && !mem_ready) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    generate
        if (MAX_WAIT > 0) begin : g_timeout
            // mem_ready arriving on the final cycle still completes the access.
            assign timeout = active && !mem_ready && (cnt == CNT_W'(MAX_WAIT - 1));
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/moore_machine_ws.sv
// Multicycle MIPS control FSM with memory wait states, a bus-timeout watchdog
// and a sticky HALT for illegal opcodes or timeouts.
module moore_machine_ws
    import moore_ws_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int STATE_W  = 4,
    parameter int EN_IMM   = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    moore_machine_ws_if.master bus
);
    state_t state, next_state;
    ctrl_t  c;
    logic   timeout;
    logic   err_q, err_cause_q;

    wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (Clk),
        .rst       (Reset),
        .active    (is_mem_state(state)),
        .mem_ready (bus.mem_ready),
        .clr       (next_state != state),
        .timeout   (timeout)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= FETCH;
            err_q       <= 1'b0;
            err_cause_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == HALT && state != HALT) begin
                err_q       <= 1'b1;
                err_cause_q <= timeout;
            end
        end
    end

    always_comb begin
        next_state = state;
        c          = '0;
        case (state)
            FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_src    = PCSRC_ALU;
                c.ir_write  = bus.mem_ready;
                c.pc_write  = bus.mem_ready;
                if (timeout)            next_state = HALT;
                else if (bus.mem_ready) next_state = DECODE;
            end
            DECODE: begin
                c.alu_src_b = SRCB_IMM_SH2;
                c.alu_op    = ALU_ADD;
                c.sn        = 1'b1;
                case (bus.Opcode)
                    OP_RTYPE:        next_state = EXEC_R;
                    OP_LW, OP_SW:    next_state = MEM_ADDR;
                    OP_BEQ, OP_BNE:  next_state = BRANCH;
                    OP_J:            next_state = JUMP;
                    OP_ADDI, OP_ORI: next_state = (EN_IMM != 0) ? EXEC_I : HALT;
                    default:         next_state = HALT;
                endcase
            end
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
                c.sn        = 1'b1;
                next_state  = (bus.Opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                c.mem_req = 1'b1;
                if (timeout)            next_state = HALT;
                else if (bus.mem_ready) next_state = WB_MEM;
            end
            MEM_WR: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                if (timeout)            next_state = HALT;
                else if (bus.mem_ready) next_state = FETCH;
            end
            WB_MEM: begin
                c.reg_write = 1'b1;
                c.reg_src   = 1'b1;
                next_state  = FETCH;
            end
            EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REGB;
                c.alu_op    = ALU_FUNCT;
                next_state  = WB_ALU;
            end
            EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                if (bus.Opcode == OP_ORI) begin
                    c.alu_op = ALU_OR;
                    c.sn     = 1'b0;
                end else begin
                    c.alu_op = ALU_ADD;
                    c.sn     = 1'b1;
                end
                next_state = WB_ALU;
            end
            WB_ALU: begin
                c.reg_write = 1'b1;
                c.reg_src   = 1'b0;
                next_state  = FETCH;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REGB;
                c.alu_op    = ALU_SUB;
                c.pc_src    = PCSRC_ALUOUT;
                c.branch    = (bus.Opcode == OP_BNE) ? BR_BNE : BR_BEQ;
                next_state  = FETCH;
            end
            JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = PCSRC_JUMP;
                next_state = FETCH;
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
        // Reset blanks the bus immediately so an access in flight cannot commit.
        if (Reset) c = '0;
    end

    assign bus.mem_req   = c.mem_req;
    assign bus.MemWrite  = c.mem_write;
    assign bus.ALUSrcA   = c.alu_src_a;
    assign bus.ALUSrcB   = c.alu_src_b;
    assign bus.ALUOp     = c.alu_op;
    assign bus.IRWrite   = c.ir_write;
    assign bus.PCWrite   = c.pc_write;
    assign bus.PCSrc     = c.pc_src;
    assign bus.Branch    = c.branch;
    assign bus.RegSrc    = c.reg_src;
    assign bus.RegWrite  = c.reg_write;
    assign bus.SN        = c.sn;
    assign bus.Stateout  = STATE_W'(state);
    assign bus.err       = err_q;
    assign bus.err_cause = err_cause_q;

endmodule

// File: tb/tb_moore_machine_ws.sv
// Randomized bench for moore_machine_ws: two configurations, each checked per
// cycle against a per-instruction expected trace built from the instruction class.
module tb_moore_machine_ws;

    localparam logic [5:0] R_OP = 6'b000000, LW_OP = 6'b100011, SW_OP = 6'b101011;
    localparam logic [5:0] BEQ_OP = 6'b000100, BNE_OP = 6'b000101, J_OP = 6'b000010;
    localparam logic [5:0] ADDI_OP = 6'b001000, ORI_OP = 6'b001101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic [5:0] opc = 6'd0;
    logic       mr  = 1'b0;
    logic       rst_a, rst_b;

    always #5 clk = ~clk;

    assign rst_a = sel ? 1'b1 : rst;
    assign rst_b = sel ? rst : 1'b1;

    moore_machine_ws_if #(.STATE_W(4)) ifa ();
    moore_machine_ws_if #(.STATE_W(6)) ifb ();

    assign ifa.Opcode    = opc;
    assign ifa.mem_ready = mr;
    assign ifb.Opcode    = opc;
    assign ifb.mem_ready = mr;

    moore_machine_ws #(.MAX_WAIT(4), .STATE_W(4), .EN_IMM(1)) dut_a (
        .Clk (clk), .Reset (rst_a), .bus (ifa)
    );
    moore_machine_ws #(.MAX_WAIT(0), .STATE_W(6), .EN_IMM(0)) dut_b (
        .Clk (clk), .Reset (rst_b), .bus (ifb)
    );

    logic [17:0] ctrl_a, ctrl_b, ctrl_obs;
    logic [7:0]  st_obs;
    logic        err_obs, cause_obs;

    assign ctrl_a = {ifa.mem_req, ifa.MemWrite, ifa.ALUSrcA, ifa.ALUSrcB, ifa.ALUOp, ifa.IRWrite,
                     ifa.PCWrite, ifa.PCSrc, ifa.Branch, ifa.RegSrc, ifa.RegWrite, ifa.SN};
    assign ctrl_b = {ifb.mem_req, ifb.MemWrite, ifb.ALUSrcA, ifb.ALUSrcB, ifb.ALUOp, ifb.IRWrite,
                     ifb.PCWrite, ifb.PCSrc, ifb.Branch, ifb.RegSrc, ifb.RegWrite, ifb.SN};
    assign ctrl_obs  = sel ? ctrl_b : ctrl_a;
    assign st_obs    = sel ? 8'(ifb.Stateout) : 8'(ifa.Stateout);
    assign err_obs   = sel ? ifb.err : ifa.err;
    assign cause_obs = sel ? ifb.err_cause : ifa.err_cause;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut=%0d got=%0h exp=%0h t=%0t", tag, sel, got, exp, $time);
        end
    endtask

    typedef struct {
        int         st;
        logic       mr;
        logic [5:0] op;
        logic       err;
        logic       cause;
    } cyc_t;

    cyc_t q[$];

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic void push(input int st, input logic m, input logic [5:0] op,
                                 input logic e, input logic c);
        cyc_t x;
        x.st = st; x.mr = m; x.op = op; x.err = e; x.cause = c;
        q.push_back(x);
    endfunction

    // Expected control word for one cycle, straight from the per-state output table.
    function automatic logic [17:0] exp_ctrl(input int st, input logic [5:0] op, input logic m);
        logic mreq, mw, srca, irw, pcw, rsrc, rw, sn;
        logic [1:0] srcb, pcsrc, br;
        logic [3:0] aop;
        {mreq, mw, srca, irw, pcw, rsrc, rw, sn} = '0;
        {srcb, pcsrc, br} = '0;
        aop = 4'b0000;
        case (st)
            0:  begin mreq = 1; srcb = 2'b01; irw = m; pcw = m; end
            1:  begin srcb = 2'b11; sn = 1; end
            2:  begin srca = 1; srcb = 2'b10; sn = 1; end
            3:  mreq = 1;
            4:  begin mreq = 1; mw = 1; end
            5:  begin rw = 1; rsrc = 1; end
            6:  begin srca = 1; aop = 4'b1111; end
            7:  begin srca = 1; srcb = 2'b10;
                      if (op == ORI_OP) aop = 4'b0011; else sn = 1; end
            8:  rw = 1;
            9:  begin srca = 1; aop = 4'b0001; pcsrc = 2'b01;
                      br = (op == BNE_OP) ? 2'b10 : 2'b01; end
            10: begin pcw = 1; pcsrc = 2'b10; end
            default: ;
        endcase
        return {mreq, mw, srca, srcb, aop, irw, pcw, pcsrc, br, rsrc, rw, sn};
    endfunction

    // A memory phase: w stalled cycles then the completing cycle, or a timeout
    // after maxw stalled cycles when the budget is enabled.
    task automatic mem_phase(input int st, input int w, input int maxw, input logic [5:0] op,
                             output bit to);
        int lows;
        to   = (maxw > 0) && (w >= maxw);
        lows = to ? maxw : w;
        for (int i = 0; i < lows; i++) push(st, 1'b0, op, 1'b0, 1'b0);
        if (!to) push(st, 1'b1, op, 1'b0, 1'b0);
    endtask

    task automatic build(input logic [5:0] op, input int wf, input int wm, input int maxw,
                         input bit en_imm, input int nhalt, output bit halted);
        bit to, ill;
        halted = 0;
        ill    = 0;
        mem_phase(0, wf, maxw, 6'($urandom), to);
        if (to) halted = 1;
        else begin
            push(1, rbit(), op, 0, 0);
            case (op)
                R_OP:    begin push(6, rbit(), op, 0, 0); push(8, rbit(), op, 0, 0); end
                LW_OP:   begin
                    push(2, rbit(), op, 0, 0);
                    mem_phase(3, wm, maxw, op, to);
                    if (to) halted = 1; else push(5, rbit(), op, 0, 0);
                end
                SW_OP:   begin
                    push(2, rbit(), op, 0, 0);
                    mem_phase(4, wm, maxw, op, to);
                    if (to) halted = 1;
                end
                BEQ_OP, BNE_OP: push(9, rbit(), op, 0, 0);
                J_OP:    push(10, rbit(), op, 0, 0);
                ADDI_OP, ORI_OP: begin
                    if (en_imm) begin push(7, rbit(), op, 0, 0); push(8, rbit(), op, 0, 0); end
                    else begin halted = 1; ill = 1; end
                end
                default: begin halted = 1; ill = 1; end
            endcase
        end
        if (halted) for (int i = 0; i < nhalt; i++) push(15, rbit(), op, 1'b1, !ill);
    endtask

    task automatic play(input int limit);
        cyc_t x;
        int   n = 0;
        while (q.size() > 0 && (limit < 0 || n < limit)) begin
            x = q.pop_front();
            @(negedge clk);
            rst = 1'b0; opc = x.op; mr = x.mr;
            #1;
            check_val("state", 32'(st_obs), 32'(x.st));
            check_val("ctrl", 32'(ctrl_obs), 32'(exp_ctrl(x.st, x.op, x.mr)));
            check_val("err", 32'(err_obs), 32'(x.err));
            check_val("err_cause", 32'(cause_obs), 32'(x.cause));
            n++;
        end
        q.delete();
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1; mr = rbit(); opc = 6'($urandom);
            #1;
            check_val("rst_ctrl", 32'(ctrl_obs), 32'd0);
            if (i == 1) begin
                check_val("rst_state", 32'(st_obs), 32'd0);
                check_val("rst_err", 32'({err_obs, cause_obs}), 32'd0);
            end
        end
    endtask

    function automatic logic [5:0] rand_op();
        case ($urandom_range(0, 9))
            0: return R_OP;   1: return LW_OP;   2: return SW_OP;  3: return BEQ_OP;
            4: return BNE_OP; 5: return J_OP;    6: return ADDI_OP; 7: return ORI_OP;
            8: return 6'($urandom);
            default: return R_OP;
        endcase
    endfunction

    task automatic run_random(input int n, input int maxw, input bit en_imm);
        bit h;
        int wf, wm;
        for (int k = 0; k < n; k++) begin
            wf = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0;
            wm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
            build(rand_op(), wf, wm, maxw, en_imm, 3, h);
            play(-1);
            if (h) do_reset();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog sim did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        // Configuration A: MAX_WAIT=4, immediates enabled.
        sel = 1'b0;
        do_reset();
        build(R_OP, 0, 0, 4, 1, 0, h);    play(-1);
        build(LW_OP, 0, 3, 4, 1, 0, h);   play(-1);
        build(BNE_OP, 0, 0, 4, 1, 0, h);  play(-1);
        build(ORI_OP, 1, 0, 4, 1, 0, h);  play(-1);
        build(ADDI_OP, 0, 0, 4, 1, 0, h); play(-1);
        build(J_OP, 2, 0, 4, 1, 0, h);    play(-1);
        build(BEQ_OP, 0, 0, 4, 1, 0, h);  play(-1);
        build(SW_OP, 0, 3, 4, 1, 0, h);   play(-1);
        build(LW_OP, 3, 0, 4, 1, 0, h);   play(-1);
        build(SW_OP, 0, 50, 4, 1, 20, h); play(-1);
        do_reset();
        build(6'b111111, 0, 0, 4, 1, 3, h); play(-1);
        do_reset();
        build(R_OP, 6, 0, 4, 1, 3, h);    play(-1);
        do_reset();
        build(SW_OP, 0, 50, 4, 1, 0, h);  play(5);
        do_reset();
        run_random(150, 4, 1);

        // Configuration B: timeout disabled, immediates illegal, 6-bit Stateout.
        sel = 1'b1;
        do_reset();
        build(ADDI_OP, 0, 0, 0, 0, 3, h); play(-1);
        do_reset();
        build(ORI_OP, 0, 0, 0, 0, 3, h);  play(-1);
        do_reset();
        build(LW_OP, 20, 20, 0, 0, 0, h); play(-1);
        run_random(80, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
